// File: rtl/ibex_cpi_pkg.sv
// Shared types and constants for the CPI-stack sampler.
package ibex_cpi_pkg;

  typedef enum logic [2:0] {
    CPI_BASE   = 3'd0,
    CPI_ICACHE = 3'd1,
    CPI_BPRED  = 3'd2,
    CPI_DCACHE = 3'd3,
    CPI_EX     = 3'd4,
    CPI_DEP    = 3'd5
  } cpi_cat_e;

  localparam int unsigned N_CPI_CAT      = 6;
  localparam int unsigned CPI_IDX_CYCLES = 6;
  localparam int unsigned CPI_IDX_UNATTR = 7;
  localparam int unsigned N_CPI_CNT      = 8;

  typedef enum logic [1:0] {
    CPI_IDLE  = 2'd0,
    CPI_RUN   = 2'd1,
    CPI_DRAIN = 2'd2
  } cpi_state_e;

endpackage

// File: rtl/ibex_cpi_sat_counter.sv
// Saturating up-counter; clear wins over increment and restarts at 0 or 1.
module ibex_cpi_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= CNT_W'(inc_i);
    end else if (inc_i && (cnt_o != CNT_MAX)) begin
      cnt_o <= cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ibex_cpi_stack_sampler.sv
// Accumulates CPI-stack attribution over fixed intervals and publishes
// each completed interval as a single-entry valid/ready snapshot.
module ibex_cpi_stack_sampler
  import ibex_cpi_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned INTERVAL = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             flush_i,
  input  logic             cat_valid_i,
  input  logic [5:0]       cat_onehot_i,
  output logic             sample_valid_o,
  input  logic             sample_ready_i,
  input  logic [2:0]       sample_idx_i,
  output logic [CNT_W-1:0] sample_data_o,
  output logic             sample_partial_o,
  output logic             overrun_o,
  output logic             cat_err_o
);

  localparam int unsigned      POS_W    = $clog2(INTERVAL);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(INTERVAL - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  cpi_state_e state_q, state_d;
  logic [POS_W-1:0]                pos_q;
  logic [N_CPI_CNT-1:0][CNT_W-1:0] cnt_q, snap_d, snap_q;
  logic [N_CPI_CNT-1:0]            inc;
  logic [N_CPI_CAT-1:0]            attr;
  logic count_en, multi_hot, slot_free, natural_end;
  logic cnt_clr, snap_load, snap_partial, drop, clr_sticky;

  assign attr        = cat_valid_i ? cat_onehot_i : '0;
  assign count_en    = (state_q == CPI_RUN) && enable_i;
  assign multi_hot   = (attr & (attr - 6'd1)) != 6'd0;
  assign slot_free   = !sample_valid_o || sample_ready_i;
  assign natural_end = (pos_q == POS_LAST);
  assign inc         = {count_en & (attr == '0), count_en, count_en ? attr : 6'd0};

  for (genvar k = 0; k < N_CPI_CNT; k++) begin : g_cnt
    ibex_cpi_sat_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .inc_i (inc[k] & ~cnt_clr),
      .clr_i (cnt_clr),
      .cnt_o (cnt_q[k])
    );
  end

  // Snapshot candidate includes this cycle's increments.
  always_comb begin
    for (int k = 0; k < N_CPI_CNT; k++) begin
      snap_d[k] = cnt_q[k];
      if (inc[k] && (cnt_q[k] != CNT_MAX)) snap_d[k] = cnt_q[k] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= CPI_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    cnt_clr      = 1'b0;
    snap_load    = 1'b0;
    snap_partial = 1'b0;
    drop         = 1'b0;
    clr_sticky   = 1'b0;
    case (state_q)
      CPI_IDLE: begin
        cnt_clr = 1'b1;
        if (enable_i) begin
          state_d    = CPI_RUN;
          clr_sticky = 1'b1;
        end
      end
      CPI_RUN: begin
        if (!enable_i) begin
          state_d = CPI_DRAIN;
        end else if (natural_end || flush_i) begin
          cnt_clr = 1'b1;
          if (slot_free) begin
            snap_load    = 1'b1;
            snap_partial = !natural_end;
          end else begin
            drop = 1'b1;
          end
        end
      end
      CPI_DRAIN: begin
        // An empty partial interval produces no snapshot.
        if (cnt_q[3'(CPI_IDX_CYCLES)] == '0) begin
          state_d = CPI_IDLE;
          cnt_clr = 1'b1;
        end else if (slot_free) begin
          snap_load    = 1'b1;
          snap_partial = 1'b1;
          state_d      = CPI_IDLE;
          cnt_clr      = 1'b1;
        end
      end
      default: state_d = CPI_IDLE;
    endcase
  end

  // Position within the interval, independent of counter saturation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       pos_q <= '0;
    else if (cnt_clr)  pos_q <= '0;
    else if (count_en) pos_q <= pos_q + POS_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      snap_q           <= '0;
      sample_valid_o   <= 1'b0;
      sample_partial_o <= 1'b0;
      overrun_o        <= 1'b0;
      cat_err_o        <= 1'b0;
    end else begin
      if (snap_load) begin
        snap_q           <= snap_d;
        sample_valid_o   <= 1'b1;
        sample_partial_o <= snap_partial;
      end else if (sample_ready_i) begin
        sample_valid_o   <= 1'b0;
      end
      if (clr_sticky)                overrun_o <= 1'b0;
      else if (drop)                 overrun_o <= 1'b1;
      if (clr_sticky)                cat_err_o <= 1'b0;
      else if (count_en && multi_hot) cat_err_o <= 1'b1;
    end
  end

  assign sample_data_o = snap_q[sample_idx_i];

endmodule
